regwrite_arbiter: RTL and testbench
===================================

# regwrite_arbiter

Arbiter and scoreboard for the single write port of the CPU register file. It shares that port between three requesters:
- the pipeline writeback stage, which can never be stalled;
- the multi-cycle unit (mul/div), which uses a valid/ready handshake;
- the debug host, which uses a valid/ready handshake.

It tracks registers with an outstanding multi-cycle result so the decode stage can stall. It drives the write-enable, address and data inputs of the register file.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive cycles debug may wait before it gets priority over the multi-cycle unit; legal range 1–15.
- DATA_W, 32: write data width.

Ports:
- iCLK  in  1  system clock; all state updates on the rising edge.
- iRST  in  1  reset, asynchronous, active-high.
- iWbValid, iWbReg, iWbData  in  1/5/32  pipeline writeback request; always served.
- iMcValid, iMcReg, iMcData  in  1/5/32  multi-cycle result request.
- oMcReady  out  1  multi-cycle request accepted this cycle.
- iDbgValid, iDbgReg, iDbgData  in  1/5/32  debug-host write request.
- oDbgReady  out  1  debug request accepted this cycle.
- iMcIssue, iMcIssueReg  in  1/5  the multi-cycle op entered execution with this destination.
- iChkRs1, iChkRs2, iChkRd  in  5 each  decode-stage source and destination registers.
- oHazard  out  1  at least one checked register is pending.
- oPending  out  32  scoreboard bit vector.
- oRegWrite, oWriteRegister, oWriteData  out  1/5/32  to the register file write port.

## Operation
- Grant is decided combinationally each cycle. Priority: WB, then the favoured one of MC/DBG.
  - MC is favoured by default.
  - DBG is favoured while the starve counter equals STARVE_LIMIT.
- oMcReady = iMcValid & granted. oDbgReady = iDbgValid & granted. Both are 0 whenever iWbValid=1.
- A requester holds valid, reg and data stable until ready; it does not drop valid before ready.
- Starve counter (4 bits):
  - increments, saturating at STARVE_LIMIT, when iDbgValid=1 and DBG is not granted;
  - clears on a DBG grant or when iDbgValid=0.
- Writes to x0 are granted normally (ready asserts), but oRegWrite stays 0 for that cycle.
- Scoreboard:
  - iMcIssue with iMcIssueReg≠0 sets pending[reg];
  - an MC grant clears pending[iMcReg];
  - a set and a clear on the same register in the same cycle: set wins;
  - pending[0] is always 0.
- oHazard = pending[iChkRs1] | pending[iChkRs2] | pending[iChkRd]. It is combinational from the registered scoreboard.
- WB and DBG grants do not touch the scoreboard.

## Timing
- oMcReady, oDbgReady and oHazard are combinational in cycle N.
- oRegWrite, oWriteRegister and oWriteData are registered. The winner of cycle N appears in cycle N+1 (one-cycle latency).
- With no grant in cycle N: oRegWrite=0 in N+1, and the address and data hold their previous values.
- A scoreboard change in cycle N is visible on oPending and oHazard in cycle N+1.
- Reset, including mid-transfer:
  - oRegWrite=0, oWriteRegister=0, oWriteData=0, oPending=0, starve counter=0;
  - ready outputs are 0 while iRST=1;
  - an accepted write whose output cycle falls during reset is dropped.
- Back-to-back grants to the same requester are allowed every cycle. Throughput is one write per cycle.

## Structure
- Shared definitions in Parametros.v: REG_ZERO (5'd0), register address width (5), DATA_W default.
- Sub-module regwrite_scoreboard holds the 32-bit pending vector, set/clear logic and the three-way hazard lookup.
- The top level holds the priority/starve logic and the output register.

## Test plan
- WB only, reg 5, data 0x1234 in cycle N → oRegWrite=1, oWriteRegister=5, oWriteData=0x1234 in N+1.
- WB, MC and DBG all valid in the same cycle → WB written. oMcReady=oDbgReady=0. Next cycle, with WB idle, MC is granted.
- MC valid every cycle and DBG valid, STARVE_LIMIT=4 → DBG is granted in its 5th waiting cycle; the counter then reads 0 and MC resumes.
- iMcIssue reg 7, then iChkRs2=7 → oHazard=1. After the MC grant for reg 7, oHazard=0 the next cycle. Issue and grant of reg 7 in the same cycle → pending[7] stays 1.
- DBG write to x0 with data 0xFFFF → oDbgReady=1, oRegWrite=0 in the next cycle.
- iRST asserted between an MC grant and its output cycle → all outputs 0 immediately. No write occurs, and oPending=0.

Source files
------------

// File: rtl/regwrite_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// register address width, the hard-wired zero register and the grant encoding.
package regwrite_arbiter_pkg;

  localparam int REG_ADDR_W     = 5;
  localparam int NUM_REGS       = 32;
  localparam int DATA_W_DEFAULT = 32;
  localparam int STARVE_W       = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

  // Which requester owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WB,
    GRANT_MC,
    GRANT_DBG
  } grant_e;

  // x0 is hard-wired, so a write to it is accepted but never reaches the file.
  function automatic logic is_real_reg(input reg_addr_t r);
    return r != REG_ZERO;
  endfunction

endpackage

// File: rtl/regwrite_arbiter_if.sv
// Bundle of every request, handshake, scoreboard and write-port signal of the
// arbiter. The master side is the pipeline/requesters; the slave side is the arbiter.
interface regwrite_arbiter_if
  import regwrite_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic                iWbValid;
  reg_addr_t           iWbReg;
  logic [DATA_W-1:0]   iWbData;

  logic                iMcValid;
  reg_addr_t           iMcReg;
  logic [DATA_W-1:0]   iMcData;
  logic                oMcReady;

  logic                iDbgValid;
  reg_addr_t           iDbgReg;
  logic [DATA_W-1:0]   iDbgData;
  logic                oDbgReady;

  logic                iMcIssue;
  reg_addr_t           iMcIssueReg;

  reg_addr_t           iChkRs1;
  reg_addr_t           iChkRs2;
  reg_addr_t           iChkRd;
  logic                oHazard;
  logic [NUM_REGS-1:0] oPending;

  logic                oRegWrite;
  reg_addr_t           oWriteRegister;
  logic [DATA_W-1:0]   oWriteData;

  modport master (
    output iWbValid, iWbReg, iWbData,
    output iMcValid, iMcReg, iMcData,
    input  oMcReady,
    output iDbgValid, iDbgReg, iDbgData,
    input  oDbgReady,
    output iMcIssue, iMcIssueReg,
    output iChkRs1, iChkRs2, iChkRd,
    input  oHazard, oPending,
    input  oRegWrite, oWriteRegister, oWriteData
  );

  modport slave (
    input  iWbValid, iWbReg, iWbData,
    input  iMcValid, iMcReg, iMcData,
    output oMcReady,
    input  iDbgValid, iDbgReg, iDbgData,
    output oDbgReady,
    input  iMcIssue, iMcIssueReg,
    input  iChkRs1, iChkRs2, iChkRd,
    output oHazard, oPending,
    output oRegWrite, oWriteRegister, oWriteData
  );

endinterface

// File: rtl/regwrite_arbiter_scoreboard.sv
// Pending-result scoreboard: one bit per architectural register that has a
// multi-cycle result in flight, plus the decode-stage hazard lookup.
module regwrite_scoreboard
  import regwrite_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  reg_addr_t           set_reg,
  input  logic                clr_en,
  input  reg_addr_t           clr_reg,
  input  reg_addr_t           rs1,
  input  reg_addr_t           rs2,
  input  reg_addr_t           rd,
  output logic [NUM_REGS-1:0] pending,
  output logic                hazard
);

  logic [NUM_REGS-1:0] pending_d;

  // Apply the clear first so that a same-cycle issue to the same register wins.
  always_comb begin
    pending_d = pending;
    if (clr_en) begin
      pending_d[clr_reg] = 1'b0;
    end
    if (set_en && is_real_reg(set_reg)) begin
      pending_d[set_reg] = 1'b1;
    end
    pending_d[REG_ZERO] = 1'b0;
  end

  // Pending vector register; changes become visible the cycle after they happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_d;
    end
  end

  assign hazard = pending[rs1] | pending[rs2] | pending[rd];

endmodule

// File: rtl/regwrite_arbiter.sv
// Arbiter for the single register-file write port. Writeback always wins;
// the multi-cycle unit is favoured over debug unless debug has waited
// STARVE_LIMIT cycles. The winner's write is registered for one cycle.
module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int DATA_W       = DATA_W_DEFAULT
) (
  input logic               iCLK,
  input logic               iRST,
  regwrite_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  grant_e              grant;
  logic                mc_favoured;
  logic [STARVE_W-1:0] starve_cnt;
  reg_addr_t           win_reg;
  logic [DATA_W-1:0]   win_data;

  logic                reg_write_q;
  reg_addr_t           write_reg_q;
  logic [DATA_W-1:0]   write_data_q;

  logic [NUM_REGS-1:0] pending;
  logic                hazard;

  assign mc_favoured = (starve_cnt != STARVE_MAX);

  // Pick this cycle's owner of the write port; nobody is granted during reset.
  always_comb begin
    grant = GRANT_NONE;
    if (!iRST) begin
      if (bus.iWbValid) begin
        grant = GRANT_WB;
      end else if (bus.iMcValid && (mc_favoured || !bus.iDbgValid)) begin
        grant = GRANT_MC;
      end else if (bus.iDbgValid) begin
        grant = GRANT_DBG;
      end
    end
  end

  // Route the winning requester's address and data toward the output register.
  always_comb begin
    win_reg  = REG_ZERO;
    win_data = '0;
    case (grant)
      GRANT_WB: begin
        win_reg  = bus.iWbReg;
        win_data = bus.iWbData;
      end
      GRANT_MC: begin
        win_reg  = bus.iMcReg;
        win_data = bus.iMcData;
      end
      GRANT_DBG: begin
        win_reg  = bus.iDbgReg;
        win_data = bus.iDbgData;
      end
      default: begin
      end
    endcase
  end

  // Count how long a pending debug request has been passed over, saturating.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      starve_cnt <= '0;
    end else if (bus.iDbgValid && (grant != GRANT_DBG)) begin
      if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Register the winner; address/data hold when idle, and x0 never enables a write.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= REG_ZERO;
      write_data_q <= '0;
    end else if (grant != GRANT_NONE) begin
      reg_write_q  <= is_real_reg(win_reg);
      write_reg_q  <= win_reg;
      write_data_q <= win_data;
    end else begin
      reg_write_q  <= 1'b0;
    end
  end

  regwrite_scoreboard u_scoreboard (
    .clk     (iCLK),
    .rst     (iRST),
    .set_en  (bus.iMcIssue),
    .set_reg (bus.iMcIssueReg),
    .clr_en  (grant == GRANT_MC),
    .clr_reg (bus.iMcReg),
    .rs1     (bus.iChkRs1),
    .rs2     (bus.iChkRs2),
    .rd      (bus.iChkRd),
    .pending (pending),
    .hazard  (hazard)
  );

  assign bus.oMcReady       = (grant == GRANT_MC);
  assign bus.oDbgReady      = (grant == GRANT_DBG);
  assign bus.oRegWrite      = reg_write_q;
  assign bus.oWriteRegister = write_reg_q;
  assign bus.oWriteData     = write_data_q;
  assign bus.oPending       = pending;
  assign bus.oHazard        = hazard;

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: a table of hand-computed vectors, hand-written
// starvation and mid-transfer reset sequences, then random traffic checked
// against a rule-level reference model.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  localparam int LIMIT = 4;
  localparam int NV    = 11;

  logic iCLK;
  logic iRST;

  regwrite_arbiter_if #(.DATA_W(32)) bus ();

  regwrite_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(32)) dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  initial begin
    iCLK = 1'b0;
    forever #5 iCLK = ~iCLK;
  end

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          wb_v;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    bit          mc_v;
    logic [4:0]  mc_reg;
    logic [31:0] mc_data;
    bit          dbg_v;
    logic [4:0]  dbg_reg;
    logic [31:0] dbg_data;
    bit          issue;
    logic [4:0]  issue_reg;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    bit          e_mc_rdy;
    bit          e_dbg_rdy;
    bit          e_hazard;
    bit          e_we;
    bit          chk_addr;
    logic [4:0]  e_wreg;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl [NV];

  // Reference model state: pending flags, cycles debug has waited, expected write port.
  bit          m_pend [32];
  int          m_wait;
  bit          m_we;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  bit          m_addr_known;
  bit          g_wb, g_mc, g_dbg;

  function automatic vec_t mkVec(input int wbv, wbr, wbd, mcv, mcr, mcd, dv, dr, dd,
                                 iss, isr, r1, r2, rdd, emc, edb, ehz, ewe, chk, ewr, ewd);
    vec_t v;
    v.wb_v      = wbv[0];
    v.wb_reg    = wbr[4:0];
    v.wb_data   = wbd;
    v.mc_v      = mcv[0];
    v.mc_reg    = mcr[4:0];
    v.mc_data   = mcd;
    v.dbg_v     = dv[0];
    v.dbg_reg   = dr[4:0];
    v.dbg_data  = dd;
    v.issue     = iss[0];
    v.issue_reg = isr[4:0];
    v.rs1       = r1[4:0];
    v.rs2       = r2[4:0];
    v.rd        = rdd[4:0];
    v.e_mc_rdy  = emc[0];
    v.e_dbg_rdy = edb[0];
    v.e_hazard  = ehz[0];
    v.e_we      = ewe[0];
    v.chk_addr  = chk[0];
    v.e_wreg    = ewr[4:0];
    v.e_wdata   = ewd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.iWbValid    = v.wb_v;
    bus.iWbReg      = v.wb_reg;
    bus.iWbData     = v.wb_data;
    bus.iMcValid    = v.mc_v;
    bus.iMcReg      = v.mc_reg;
    bus.iMcData     = v.mc_data;
    bus.iDbgValid   = v.dbg_v;
    bus.iDbgReg     = v.dbg_reg;
    bus.iDbgData    = v.dbg_data;
    bus.iMcIssue    = v.issue;
    bus.iMcIssueReg = v.issue_reg;
    bus.iChkRs1     = v.rs1;
    bus.iChkRs2     = v.rs2;
    bus.iChkRd      = v.rd;
  endtask

  task automatic clearInputs();
    vec_t v;
    v = mkVec(0,0,0, 0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0,0,0,0);
    applyStimulus(v);
  endtask

  function automatic logic [31:0] pendVec();
    logic [31:0] p;
    p = '0;
    for (int r = 0; r < 32; r++) p[r] = m_pend[r];
    return p;
  endfunction

  task automatic modelReset();
    for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    m_wait       = 0;
    m_we         = 1'b0;
    m_wreg       = 5'd0;
    m_wdata      = 32'd0;
    m_addr_known = 1'b1;
  endtask

  // Decide the winner from the priority rules and compare every visible output.
  task automatic modelCheck();
    g_wb  = 1'b0;
    g_mc  = 1'b0;
    g_dbg = 1'b0;
    if (bus.iWbValid) g_wb = 1'b1;
    else if (bus.iMcValid && bus.iDbgValid) begin
      if (m_wait >= LIMIT) g_dbg = 1'b1;
      else                 g_mc  = 1'b1;
    end
    else if (bus.iMcValid)  g_mc  = 1'b1;
    else if (bus.iDbgValid) g_dbg = 1'b1;

    checkOutput("mc_ready",  bus.oMcReady,  g_mc);
    checkOutput("dbg_ready", bus.oDbgReady, g_dbg);
    checkOutput("hazard",    bus.oHazard,
                m_pend[bus.iChkRs1] | m_pend[bus.iChkRs2] | m_pend[bus.iChkRd]);
    checkOutput("pending",   bus.oPending,  pendVec());
    checkOutput("reg_write", bus.oRegWrite, m_we);
    if (m_addr_known) begin
      checkOutput("write_reg",  bus.oWriteRegister, m_wreg);
      checkOutput("write_data", bus.oWriteData,     m_wdata);
    end
  endtask

  // Advance the model by one clock using the inputs that were present at the edge.
  task automatic modelCommit();
    logic [4:0]  r;
    logic [31:0] d;
    r = 5'd0;
    d = 32'd0;
    if (g_wb)  begin r = bus.iWbReg;  d = bus.iWbData;  end
    if (g_mc)  begin r = bus.iMcReg;  d = bus.iMcData;  end
    if (g_dbg) begin r = bus.iDbgReg; d = bus.iDbgData; end
    if (g_wb || g_mc || g_dbg) begin
      m_we = (r != 5'd0);
      if (r != 5'd0) begin
        m_wreg       = r;
        m_wdata      = d;
        m_addr_known = 1'b1;
      end else begin
        m_addr_known = 1'b0;
      end
    end else begin
      m_we = 1'b0;
    end
    if (bus.iDbgValid && !g_dbg) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
    else                         m_wait = 0;
    if (g_mc) m_pend[bus.iMcReg] = 1'b0;
    if (bus.iMcIssue && bus.iMcIssueReg != 5'd0) m_pend[bus.iMcIssueReg] = 1'b1;
  endtask

  task automatic runCycle();
    @(negedge iCLK);
    modelCheck();
    @(posedge iCLK);
    modelCommit();
    #1;
  endtask

  initial begin
    bit         mc_busy, dbg_busy;
    logic [4:0] mc_r, dbg_r;
    logic [31:0] mc_d, dbg_d;

    //              wb          mc             dbg              issue  chk      rdy/haz  we chk reg data
    tbl[0]  = mkVec(1,5,'h1234, 0,0,0,         0,0,0,           0,0,   0,0,0,   0,0,0,   1,1,5,'h1234);
    tbl[1]  = mkVec(0,0,0,      0,0,0,         0,0,0,           0,0,   0,0,0,   0,0,0,   0,1,5,'h1234);
    tbl[2]  = mkVec(1,3,'hAAAA, 1,9,'h99,      1,10,'hD0,       1,7,   0,7,0,   0,0,0,   1,1,3,'hAAAA);
    tbl[3]  = mkVec(0,0,0,      1,9,'h99,      1,10,'hD0,       0,0,   0,7,0,   1,0,1,   1,1,9,'h99);
    tbl[4]  = mkVec(0,0,0,      1,7,'h77,      1,10,'hD0,       0,0,   0,7,0,   1,0,1,   1,1,7,'h77);
    tbl[5]  = mkVec(0,0,0,      0,0,0,         1,10,'hD0,       0,0,   0,7,0,   0,1,0,   1,1,10,'hD0);
    tbl[6]  = mkVec(0,0,0,      0,0,0,         1,0,'hFFFF,      0,0,   0,0,0,   0,1,0,   0,0,0,0);
    tbl[7]  = mkVec(0,0,0,      1,7,'h55,      0,0,0,           1,7,   0,7,0,   1,0,0,   1,1,7,'h55);
    tbl[8]  = mkVec(0,0,0,      0,0,0,         0,0,0,           0,0,   0,7,0,   0,0,1,   0,1,7,'h55);
    tbl[9]  = mkVec(0,0,0,      0,0,0,         0,0,0,           1,0,   0,0,0,   0,0,0,   0,1,7,'h55);
    tbl[10] = mkVec(0,0,0,      0,0,0,         0,0,0,           0,0,   3,0,7,   0,0,1,   0,1,7,'h55);

    // Reset with requests present: no handshake may complete and outputs are cleared.
    iRST = 1'b1;
    clearInputs();
    bus.iMcValid  = 1'b1;
    bus.iDbgValid = 1'b1;
    modelReset();
    @(posedge iCLK);
    @(posedge iCLK);
    @(negedge iCLK);
    checkOutput("rst_mc_ready",   bus.oMcReady,       0);
    checkOutput("rst_dbg_ready",  bus.oDbgReady,      0);
    checkOutput("rst_reg_write",  bus.oRegWrite,      0);
    checkOutput("rst_write_reg",  bus.oWriteRegister, 0);
    checkOutput("rst_write_data", bus.oWriteData,     0);
    checkOutput("rst_pending",    bus.oPending,       0);
    @(posedge iCLK);
    #1;
    clearInputs();
    iRST = 1'b0;

    // Table of hand-computed vectors, run from the reset state.
    for (int i = 0; i < NV; i++) begin
      applyStimulus(tbl[i]);
      @(negedge iCLK);
      checkOutput($sformatf("t%0d_mc_ready", i),  bus.oMcReady,  tbl[i].e_mc_rdy);
      checkOutput($sformatf("t%0d_dbg_ready", i), bus.oDbgReady, tbl[i].e_dbg_rdy);
      checkOutput($sformatf("t%0d_hazard", i),    bus.oHazard,   tbl[i].e_hazard);
      modelCheck();
      @(posedge iCLK);
      modelCommit();
      #1;
      checkOutput($sformatf("t%0d_reg_write", i), bus.oRegWrite, tbl[i].e_we);
      if (tbl[i].chk_addr) begin
        checkOutput($sformatf("t%0d_write_reg", i),  bus.oWriteRegister, tbl[i].e_wreg);
        checkOutput($sformatf("t%0d_write_data", i), bus.oWriteData,     tbl[i].e_wdata);
      end
    end

    // Starvation: MC always valid; debug wins its 5th waiting cycle, then MC resumes.
    clearInputs();
    for (int k = 0; k < 6; k++) begin
      bus.iMcValid  = 1'b1;
      bus.iMcReg    = 5'(11 + k);
      bus.iMcData   = 32'h100 + k;
      bus.iDbgValid = 1'b1;
      bus.iDbgReg   = (k < 5) ? 5'd20 : 5'd21;
      bus.iDbgData  = (k < 5) ? 32'hDB : 32'hDC;
      @(negedge iCLK);
      checkOutput($sformatf("starve%0d_mc_ready", k),  bus.oMcReady,  (k == 4) ? 0 : 1);
      checkOutput($sformatf("starve%0d_dbg_ready", k), bus.oDbgReady, (k == 4) ? 1 : 0);
      modelCheck();
      @(posedge iCLK);
      modelCommit();
      #1;
    end
    clearInputs();
    runCycle();

    // Reset between an MC grant and its output cycle drops the write and the scoreboard.
    bus.iMcIssue    = 1'b1;
    bus.iMcIssueReg = 5'd12;
    runCycle();
    bus.iMcIssue = 1'b0;
    bus.iChkRs1  = 5'd12;
    bus.iMcValid = 1'b1;
    bus.iMcReg   = 5'd3;
    bus.iMcData  = 32'hBEEF;
    @(negedge iCLK);
    modelCheck();
    iRST = 1'b1;
    #1;
    checkOutput("midrst_mc_ready",   bus.oMcReady,       0);
    checkOutput("midrst_reg_write",  bus.oRegWrite,      0);
    checkOutput("midrst_write_reg",  bus.oWriteRegister, 0);
    checkOutput("midrst_write_data", bus.oWriteData,     0);
    checkOutput("midrst_pending",    bus.oPending,       0);
    checkOutput("midrst_hazard",     bus.oHazard,        0);
    modelReset();
    @(posedge iCLK);
    #1;
    checkOutput("midrst_drop_write", bus.oRegWrite,      0);
    checkOutput("midrst_drop_reg",   bus.oWriteRegister, 0);
    clearInputs();
    iRST = 1'b0;
    runCycle();

    // Random traffic; requesters hold their request stable until accepted.
    mc_busy  = 1'b0;
    dbg_busy = 1'b0;
    mc_r = 5'd0; mc_d = 32'd0; dbg_r = 5'd0; dbg_d = 32'd0;
    for (int c = 0; c < 400; c++) begin
      if (!mc_busy && ($urandom_range(0, 1) == 1)) begin
        mc_busy = 1'b1;
        mc_r    = 5'($urandom);
        mc_d    = $urandom;
      end
      if (!dbg_busy && ($urandom_range(0, 2) == 0)) begin
        dbg_busy = 1'b1;
        dbg_r    = 5'($urandom);
        dbg_d    = $urandom;
      end
      bus.iWbValid    = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 2) != 0);
      bus.iWbReg      = 5'($urandom);
      bus.iWbData     = $urandom;
      bus.iMcValid    = mc_busy;
      bus.iMcReg      = mc_r;
      bus.iMcData     = mc_d;
      bus.iDbgValid   = dbg_busy;
      bus.iDbgReg     = dbg_r;
      bus.iDbgData    = dbg_d;
      bus.iMcIssue    = ($urandom_range(0, 3) == 0);
      bus.iMcIssueReg = 5'($urandom);
      bus.iChkRs1     = 5'($urandom);
      bus.iChkRs2     = 5'($urandom);
      bus.iChkRd      = 5'($urandom);
      runCycle();
      if (g_mc)  mc_busy  = 1'b0;
      if (g_dbg) dbg_busy = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
